nbit_shift_register: RTL and testbench

NBIT_SHIFT_REGISTER -- requirements
Module: nbit_shift_register

---
 rtl/nbit_shift_register.sv | 66 ++++++
 tb/tb_nbit_shift_register.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nbit_shift_register.sv
// nbit_shift_register: framed parallel-load shift register for serial TX/RX.
// A load starts a frame; each shift strobe moves one bit; after WIDTH shifts
// the frame ends with a one-cycle done pulse and the register holds.
module nbit_shift_register #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] PRELOAD   = '0,
  parameter bit               SHIFT_DIR = 1'b0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  input  logic             ld,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shifted;

  // Direction is fixed at elaboration: pick the next-shift value and the
  // outgoing bit from the end that leaves first.
  if (SHIFT_DIR == 1'b0) begin : g_right
    assign shifted = {ser_in, q[WIDTH-1:1]};
    assign ser_out = q[0];
  end else begin : g_left
    assign shifted = {q[WIDTH-2:0], ser_in};
    assign ser_out = q[WIDTH-1];
  end

  // Frame control: clear beats load, load beats shift; the last shift of a
  // frame drops busy and raises done for exactly one cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      q     <= PRELOAD;
      count <= '0;
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        q     <= d;
        count <= '0;
        state <= SHIFT;
        busy  <= 1'b1;
      end else if (state == SHIFT && shift_en) begin
        q     <= shifted;
        count <= count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nbit_shift_register.sv
// Bench for nbit_shift_register: directed TX/RX/left/priority/clear frames,
// expected values queued as stimulus is driven and checked as results appear.
module tb_nbit_shift_register;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          clear, ld, shift_en, ser_in;
  logic [W-1:0]  d;
  logic [W-1:0]  q_r, q_l;
  logic          so_r, so_l, busy_r, busy_l, done_r, done_l;
  logic [CW-1:0] cnt_r, cnt_l;

  int n_run = 0, n_fail = 0, done_seen = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  nbit_shift_register #(.WIDTH(W), .PRELOAD(8'h55), .SHIFT_DIR(1'b0)) u_r (
    .clk(clk), .clear(clear), .d(d), .ld(ld), .shift_en(shift_en),
    .ser_in(ser_in), .q(q_r), .ser_out(so_r), .count(cnt_r),
    .busy(busy_r), .done(done_r)
  );

  nbit_shift_register #(.WIDTH(W), .SHIFT_DIR(1'b1)) u_l (
    .clk(clk), .clear(clear), .d(d), .ld(ld), .shift_en(shift_en),
    .ser_in(ser_in), .q(q_l), .ser_out(so_l), .count(cnt_l),
    .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    sb_t s;
    n_run++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0h required an expected entry", obs);
      return;
    end
    s = sbq.pop_front();
    assert (obs === s.exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", s.tag, obs, s.exp);
    end
  endtask

  task automatic exp_st(input string t, input logic [7:0] eq, input int ec,
                        input bit eb, input bit ed);
    push({t, " q"}, 32'(eq));
    push({t, " count"}, 32'(ec));
    push({t, " busy"}, 32'(eb));
    push({t, " done"}, 32'(ed));
  endtask

  task automatic got_st();
    pop_chk(32'(q_r));
    pop_chk(32'(cnt_r));
    pop_chk(32'(busy_r));
    pop_chk(32'(done_r));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done_r === 1'b1) done_seen++;
  endtask

  initial begin
    logic [7:0] eq, txd, lx;
    bit         rx [8];
    rx = '{1, 1, 0, 0, 1, 0, 1, 0};

    // reset
    clear = 1'b1; ld = 1'b0; shift_en = 1'b0; ser_in = 1'b0; d = '0;
    exp_st("reset", 8'h55, 0, 0, 0);
    push("reset left q", 32'h0);
    tick();
    got_st();
    pop_chk(32'(q_l));
    clear = 1'b0;

    // TX frame, right shift, ser_in=1
    d = 8'hA5; ld = 1'b1;
    exp_st("tx ld", 8'hA5, 0, 1, 0);
    tick();
    got_st();
    ld = 1'b0; ser_in = 1'b1; eq = 8'hA5; txd = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      push("tx ser_out", 32'(txd[i]));
      pop_chk(32'(so_r));
      shift_en = 1'b1;
      eq = {1'b1, eq[7:1]};
      exp_st("tx shift", eq, i + 1, i < 7, i == 7);
      tick();
      got_st();
      shift_en = 1'b0;
    end
    exp_st("tx hold", 8'hFF, 8, 0, 0);
    tick();
    got_st();

    // shift_en in IDLE is ignored
    shift_en = 1'b1;
    exp_st("idle shift", 8'hFF, 8, 0, 0);
    tick();
    got_st();
    shift_en = 1'b0;

    // RX frame, strobes 16 cycles apart
    d = 8'h00; ld = 1'b1;
    exp_st("rx ld", 8'h00, 0, 1, 0);
    tick();
    got_st();
    ld = 1'b0; eq = 8'h00; done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      ser_in = rx[i]; shift_en = 1'b1;
      eq = {rx[i], eq[7:1]};
      tick();
      shift_en = 1'b0;
      for (int g = 0; g < 15; g++) tick();
      push("rx gap q", 32'(eq));
      pop_chk(32'(q_r));
      push("rx gap count", 32'(i + 1));
      pop_chk(32'(cnt_r));
    end
    push("rx final q", 32'h53);
    pop_chk(32'(q_r));
    push("rx done pulses", 32'd1);
    pop_chk(32'(done_seen));

    // ld together with the final shift wins
    d = 8'h00; ld = 1'b1;
    tick();
    ld = 1'b0; ser_in = 1'b0; shift_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    push("prio pre count", 32'd7);
    pop_chk(32'(cnt_r));
    d = 8'h3C; ld = 1'b1;
    exp_st("prio", 8'h3C, 0, 1, 0);
    tick();
    got_st();
    ld = 1'b0; shift_en = 1'b0;
    exp_st("prio after", 8'h3C, 0, 1, 0);
    tick();
    got_st();

    // clear mid-frame, asserted together with ld and shift_en
    done_seen = 0;
    shift_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    push("clear pre count", 32'd4);
    pop_chk(32'(cnt_r));
    clear = 1'b1; ld = 1'b1; d = 8'hEE;
    exp_st("clear", 8'h55, 0, 0, 0);
    tick();
    got_st();
    clear = 1'b0; ld = 1'b0; shift_en = 1'b0;
    exp_st("post clear", 8'h55, 0, 0, 0);
    tick();
    got_st();
    push("clear done pulses", 32'd0);
    pop_chk(32'(done_seen));

    // left-shift instance
    d = 8'h81; ld = 1'b1;
    tick();
    ld = 1'b0; ser_in = 1'b0; lx = 8'h81;
    for (int i = 0; i < 8; i++) begin
      push("left ser_out", 32'(lx[7 - i]));
      pop_chk(32'(so_l));
      shift_en = 1'b1;
      tick();
      shift_en = 1'b0;
    end
    push("left q", 32'h00);
    pop_chk(32'(q_l));
    push("left count", 32'd8);
    pop_chk(32'(cnt_l));
    push("left busy", 32'd0);
    pop_chk(32'(busy_l));
    push("left done", 32'd1);
    pop_chk(32'(done_l));
    tick();
    push("left done drop", 32'd0);
    pop_chk(32'(done_l));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
